// File: rtl/i2c_slave_regs.sv
// -----------------------------------------------------------------------------
// i2c_slave_regs
//   I2C slave with a small bank of 8-bit registers. The master writes a
//   register pointer and then any number of data bytes, or reads from the
//   current pointer. The pointer wraps at NREG-1 and keeps its value between
//   transactions, so "write pointer, repeated START, read" performs a random
//   read. SCL/SDA are oversampled by clk.
//
// Ports
//   clk       system clock, at least 8x the SCL rate
//   rst       asynchronous active-low reset
//   scl       I2C clock from the master
//   sda_in    sampled SDA line level
//   sda_oe    1 = pull SDA low (open drain), 0 = release
//   busy      high while a transaction addressed to this device is running
//   wr_valid  one-clk pulse per register write
//   wr_addr   register index written (valid with wr_valid)
//   wr_data   byte written (valid with wr_valid)
// -----------------------------------------------------------------------------
module i2c_slave_regs #(
   parameter logic [6:0] DEV_ADDR = 7'b1000000,
   parameter int         NREG     = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic       busy,
   output logic       wr_valid,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data
);

   localparam int               PTR_W    = (NREG > 1) ? $clog2(NREG) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREG - 1);
   localparam logic [8:0]       NREG_LIM = 9'(NREG);

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR,
      S_ADDR_ACK,
      S_REG,
      S_REG_ACK,
      S_WDATA,
      S_WDATA_ACK,
      S_RDATA,
      S_RDATA_ACK,
      S_WAIT_STOP
   } state_t;

   // Synchronizers plus one extra stage of history for edge detection
   logic scl_s1_q, scl_s2_q, scl_prev_q;
   logic sda_s1_q, sda_s2_q, sda_prev_q;

   state_t           state_q,     state_d;
   logic [2:0]       bit_cnt_q,   bit_cnt_d;
   logic [7:0]       shreg_q,     shreg_d;
   // In the ACK states: set once the ACK slot is on the bus (slave ACK) or
   // once the master ACK has been seen (read ACK).
   logic             ack_phase_q, ack_phase_d;
   logic             rw_q,        rw_d;
   logic [PTR_W-1:0] ptr_q,       ptr_d;
   logic             sda_oe_q,    sda_oe_d;
   logic             busy_q,      busy_d;
   logic             wr_valid_q,  wr_valid_d;
   logic [7:0]       wr_addr_q,   wr_addr_d;
   logic [7:0]       wr_data_q,   wr_data_d;

   logic [7:0]       regs_q [NREG];
   logic             reg_we;

   logic             scl_rise, scl_fall, start_det, stop_det;
   logic [7:0]       rx_byte;
   logic [7:0]       rd_byte;
   logic [PTR_W-1:0] ptr_inc;

   assign scl_rise  = scl_s2_q & ~scl_prev_q;
   assign scl_fall  = ~scl_s2_q & scl_prev_q;
   // SCL must be high in both samples so an SDA change right at an SCL edge
   // is never mistaken for a bus condition.
   assign start_det = scl_s2_q & scl_prev_q & sda_prev_q & ~sda_s2_q;
   assign stop_det  = scl_s2_q & scl_prev_q & ~sda_prev_q & sda_s2_q;

   // Byte as it will be once the bit sampled on this rising edge is shifted in
   assign rx_byte = {shreg_q[6:0], sda_s2_q};
   assign rd_byte = regs_q[ptr_q];
   assign ptr_inc = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      ack_phase_d = ack_phase_q;
      rw_d        = rw_q;
      ptr_d       = ptr_q;
      sda_oe_d    = sda_oe_q;
      busy_d      = busy_q;
      wr_valid_d  = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      reg_we      = 1'b0;

      if (stop_det) begin
         state_d     = S_IDLE;
         sda_oe_d    = 1'b0;
         busy_d      = 1'b0;
         ack_phase_d = 1'b0;
      end else if (start_det) begin
         // Also the repeated-START path; busy comes back on address match
         state_d     = S_ADDR;
         bit_cnt_d   = '0;
         sda_oe_d    = 1'b0;
         busy_d      = 1'b0;
         ack_phase_d = 1'b0;
      end else begin
         case (state_q)
            S_ADDR: begin
               if (scl_rise) begin
                  shreg_d   = rx_byte;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     if (rx_byte[7:1] == DEV_ADDR) begin
                        state_d = S_ADDR_ACK;
                        busy_d  = 1'b1;
                        rw_d    = rx_byte[0];
                     end else begin
                        state_d = S_WAIT_STOP;
                     end
                  end
               end
            end

            S_ADDR_ACK: begin
               if (scl_fall) begin
                  if (!ack_phase_q) begin
                     ack_phase_d = 1'b1;
                     sda_oe_d    = 1'b1;
                  end else begin
                     ack_phase_d = 1'b0;
                     bit_cnt_d   = '0;
                     if (rw_q) begin
                        // MSB goes out on the same fall that ends the ACK
                        state_d  = S_RDATA;
                        shreg_d  = rd_byte;
                        sda_oe_d = ~rd_byte[7];
                     end else begin
                        state_d  = S_REG;
                        sda_oe_d = 1'b0;
                     end
                  end
               end
            end

            S_REG: begin
               if (scl_rise) begin
                  shreg_d   = rx_byte;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     if ({1'b0, rx_byte} < NREG_LIM) begin
                        ptr_d   = rx_byte[PTR_W-1:0];
                        state_d = S_REG_ACK;
                     end else begin
                        state_d = S_WAIT_STOP;
                     end
                  end
               end
            end

            S_REG_ACK, S_WDATA_ACK: begin
               if (scl_fall) begin
                  if (!ack_phase_q) begin
                     ack_phase_d = 1'b1;
                     sda_oe_d    = 1'b1;
                  end else begin
                     ack_phase_d = 1'b0;
                     sda_oe_d    = 1'b0;
                     bit_cnt_d   = '0;
                     state_d     = S_WDATA;
                  end
               end
            end

            S_WDATA: begin
               if (scl_rise) begin
                  shreg_d   = rx_byte;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     reg_we     = 1'b1;
                     wr_valid_d = 1'b1;
                     wr_addr_d  = 8'(ptr_q);
                     wr_data_d  = rx_byte;
                     ptr_d      = ptr_inc;
                     state_d    = S_WDATA_ACK;
                  end
               end
            end

            S_RDATA: begin
               if (scl_fall) begin
                  if (bit_cnt_q == 3'd7) begin
                     // All 8 bits are out: release for the master's ACK bit
                     sda_oe_d    = 1'b0;
                     ptr_d       = ptr_inc;
                     bit_cnt_d   = '0;
                     ack_phase_d = 1'b0;
                     state_d     = S_RDATA_ACK;
                  end else begin
                     // Rotate so the next bit to send sits in bit 7
                     shreg_d   = {shreg_q[6:0], shreg_q[7]};
                     sda_oe_d  = ~shreg_q[6];
                     bit_cnt_d = bit_cnt_q + 3'd1;
                  end
               end
            end

            S_RDATA_ACK: begin
               if (scl_rise) begin
                  if (!sda_s2_q) begin
                     ack_phase_d = 1'b1;
                  end else begin
                     state_d = S_WAIT_STOP;
                  end
               end else if (scl_fall && ack_phase_q) begin
                  ack_phase_d = 1'b0;
                  shreg_d     = rd_byte;
                  sda_oe_d    = ~rd_byte[7];
                  bit_cnt_d   = '0;
                  state_d     = S_RDATA;
               end
            end

            default: begin
               // S_IDLE and S_WAIT_STOP: only START/STOP leave these
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scl_s1_q    <= 1'b1;
         scl_s2_q    <= 1'b1;
         scl_prev_q  <= 1'b1;
         sda_s1_q    <= 1'b1;
         sda_s2_q    <= 1'b1;
         sda_prev_q  <= 1'b1;
         state_q     <= S_IDLE;
         bit_cnt_q   <= '0;
         shreg_q     <= '0;
         ack_phase_q <= 1'b0;
         rw_q        <= 1'b0;
         ptr_q       <= '0;
         sda_oe_q    <= 1'b0;
         busy_q      <= 1'b0;
         wr_valid_q  <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else begin
         scl_s1_q    <= scl;
         scl_s2_q    <= scl_s1_q;
         scl_prev_q  <= scl_s2_q;
         sda_s1_q    <= sda_in;
         sda_s2_q    <= sda_s1_q;
         sda_prev_q  <= sda_s2_q;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         ack_phase_q <= ack_phase_d;
         rw_q        <= rw_d;
         ptr_q       <= ptr_d;
         sda_oe_q    <= sda_oe_d;
         busy_q      <= busy_d;
         wr_valid_q  <= wr_valid_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= 8'h00;
         end
      end else if (reg_we) begin
         regs_q[ptr_q] <= rx_byte;
      end
   end

   assign sda_oe   = sda_oe_q;
   assign busy     = busy_q;
   assign wr_valid = wr_valid_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// -----------------------------------------------------------------------------
// tb_i2c_slave_regs
//   Bit-banged I2C master driving i2c_slave_regs. Write transactions come
//   from a vector table; reads, burst wrap, pointer persistence and reset
//   during a read are hand-written sequences. Expected register writes are
//   queued when the data byte is sent and matched against wr_valid pulses.
// -----------------------------------------------------------------------------
module tb_i2c_slave_regs;

   logic       clk;
   logic       rst;
   logic       scl;
   logic       sda_m;
   logic       sda_line;
   logic       sda_oe;
   logic       busy;
   logic       wr_valid;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;

   // Open-drain bus: low if either side pulls it low
   assign sda_line = sda_m & ~sda_oe;

   i2c_slave_regs #(
      .DEV_ADDR(7'h40),
      .NREG    (16)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .scl     (scl),
      .sda_in  (sda_line),
      .sda_oe  (sda_oe),
      .busy    (busy),
      .wr_valid(wr_valid),
      .wr_addr (wr_addr),
      .wr_data (wr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] d;
   } wr_t;

   typedef struct {
      logic [7:0] dev;
      logic [7:0] reg_a;
      logic [7:0] data;
      logic       dev_ack;
      logic       reg_ack;
      logic       data_ack;
      logic       wr;
   } wvec_t;

   int         checks;
   int         errors;
   int         wr_count;
   int         busy_cycles;
   wr_t        sb_q [$];
   logic [7:0] model_regs [16];
   wvec_t      tbl [7];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%02h required=0x%02h", name, act, req);
      end
   endtask

   // Called once per clock by every wait, so all DUT activity is observed
   task automatic monitor_cycle();
      wr_t e;
      if (rst) begin
         if (busy) busy_cycles++;
         if (sda_oe && !busy) check("sda_oe_while_not_busy", 8'(sda_oe), 8'd0);
         if (wr_valid) begin
            wr_count++;
            if (sb_q.size() == 0) begin
               check("wr_valid_unexpected", 8'(wr_valid), 8'd0);
            end else begin
               e = sb_q.pop_front();
               check("wr_addr", wr_addr, e.a);
               check("wr_data", wr_data, e.d);
            end
         end
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         monitor_cycle();
      end
   endtask

   // Entered and left with SCL low; line is the bus level while SCL is high
   task automatic send_bit(input logic b, output logic line);
      tick(4);
      sda_m = b;
      tick(4);
      scl = 1'b1;
      tick(4);
      line = sda_line;
      tick(4);
      scl = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, output logic acked);
      logic line;
      for (int i = 7; i >= 0; i--) send_bit(b[i], line);
      send_bit(1'b1, line);
      acked = ~line;
   endtask

   task automatic recv_byte(input logic master_ack, output logic [7:0] b, output logic ack_line);
      logic line;
      for (int i = 7; i >= 0; i--) begin
         send_bit(1'b1, line);
         b[i] = line;
      end
      send_bit(~master_ack, ack_line);
   endtask

   task automatic i2c_start();
      tick(4);
      sda_m = 1'b1;
      tick(4);
      scl = 1'b1;
      tick(6);
      sda_m = 1'b0;
      tick(6);
      scl = 1'b0;
   endtask

   task automatic i2c_stop();
      tick(4);
      sda_m = 1'b0;
      tick(4);
      scl = 1'b1;
      tick(6);
      sda_m = 1'b1;
      tick(8);
   endtask

   task automatic write_row(input wvec_t v, input int idx);
      logic a0, a1, a2;
      int   wc0, bc0;
      wc0 = wr_count;
      bc0 = busy_cycles;
      i2c_start();
      send_byte(v.dev, a0);
      check($sformatf("w%0d_dev_ack", idx), 8'(a0), 8'(v.dev_ack));
      send_byte(v.reg_a, a1);
      check($sformatf("w%0d_reg_ack", idx), 8'(a1), 8'(v.reg_ack));
      if (v.wr) begin
         sb_q.push_back('{a: v.reg_a, d: v.data});
         model_regs[v.reg_a[3:0]] = v.data;
      end
      send_byte(v.data, a2);
      check($sformatf("w%0d_data_ack", idx), 8'(a2), 8'(v.data_ack));
      i2c_stop();
      check($sformatf("w%0d_wr_pulses", idx), 8'(wr_count - wc0), 8'(v.wr));
      if (!v.dev_ack) check($sformatf("w%0d_busy_cycles", idx), 8'(busy_cycles - bc0), 8'd0);
      check($sformatf("w%0d_busy_after_stop", idx), 8'(busy), 8'd0);
      $display("txn write %0d: dev=%02h reg=%02h data=%02h acks=%b%b%b", idx, v.dev, v.reg_a, v.data, a0, a1, a2);
   endtask

   task automatic read_regs(input logic [7:0] start_reg, input int n);
      logic       ack;
      logic       line;
      logic [7:0] b;
      i2c_start();
      send_byte(8'h80, ack);
      check("rd_dev_w_ack", 8'(ack), 8'd1);
      send_byte(start_reg, ack);
      check("rd_reg_ack", 8'(ack), 8'd1);
      i2c_start();
      send_byte(8'h81, ack);
      check("rd_dev_r_ack", 8'(ack), 8'd1);
      for (int i = 0; i < n; i++) begin
         recv_byte(i != n - 1, b, line);
         check($sformatf("rd_byte_%02h", 4'(start_reg + 8'(i))), b, model_regs[4'(start_reg + 8'(i))]);
         if (i == n - 1) check("rd_nack_slot_released", 8'(line), 8'd1);
         $display("txn read: reg=%02h data=%02h", 4'(start_reg + 8'(i)), b);
      end
      tick(6);
      check("rd_oe_after_nack", 8'(sda_oe), 8'd0);
      i2c_stop();
   endtask

   initial begin
      logic       ack;
      logic       line;
      logic [7:0] b;
      int         wc0;

      checks      = 0;
      errors      = 0;
      wr_count    = 0;
      busy_cycles = 0;
      for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;

      //          dev    reg    data   dack  rack  dtack wr
      tbl[0] = '{8'h80, 8'h01, 8'hBA, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[1] = '{8'h80, 8'h03, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[2] = '{8'h82, 8'h01, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{8'h80, 8'h10, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[4] = '{8'h80, 8'hFF, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{8'h00, 8'h02, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[6] = '{8'h80, 8'h0E, 8'hC5, 1'b1, 1'b1, 1'b1, 1'b1};

      rst   = 1'b0;
      scl   = 1'b1;
      sda_m = 1'b1;
      tick(3);
      check("reset_sda_oe",   8'(sda_oe),   8'd0);
      check("reset_busy",     8'(busy),     8'd0);
      check("reset_wr_valid", 8'(wr_valid), 8'd0);
      check("reset_wr_addr",  wr_addr,      8'h00);
      check("reset_wr_data",  wr_data,      8'h00);
      rst = 1'b1;
      tick(6);

      for (int r = 0; r < 7; r++) write_row(tbl[r], r);

      // Random read of reg 1 via repeated START: expects 0xBA
      read_regs(8'h01, 1);
      // Sequential read across the wrap point: 14, 15, 0
      read_regs(8'h0E, 3);

      // Burst write wrapping 15 -> 0
      wc0 = wr_count;
      i2c_start();
      send_byte(8'h80, ack);
      check("burst_dev_ack", 8'(ack), 8'd1);
      send_byte(8'h0F, ack);
      check("burst_reg_ack", 8'(ack), 8'd1);
      sb_q.push_back('{a: 8'h0F, d: 8'h11});
      model_regs[15] = 8'h11;
      send_byte(8'h11, ack);
      check("burst_d0_ack", 8'(ack), 8'd1);
      sb_q.push_back('{a: 8'h00, d: 8'h22});
      model_regs[0] = 8'h22;
      send_byte(8'h22, ack);
      check("burst_d1_ack", 8'(ack), 8'd1);
      i2c_stop();
      check("burst_wr_pulses", 8'(wr_count - wc0), 8'd2);
      $display("txn burst write: reg=0f data=11,22");
      read_regs(8'h0F, 2);

      // Pointer now 1 after reading 15 and 0: current-address read
      i2c_start();
      send_byte(8'h81, ack);
      check("cur_rd_dev_ack", 8'(ack), 8'd1);
      recv_byte(1'b0, b, line);
      check("cur_rd_byte", b, model_regs[1]);
      i2c_stop();
      $display("txn current read: data=%02h", b);

      // Reset in the middle of a read of reg 0 (0x22): bit 4 is a 0, so the
      // slave is pulling SDA low when reset hits.
      i2c_start();
      send_byte(8'h80, ack);
      send_byte(8'h00, ack);
      check("rstrd_reg_ack", 8'(ack), 8'd1);
      i2c_start();
      send_byte(8'h81, ack);
      check("rstrd_dev_ack", 8'(ack), 8'd1);
      for (int i = 0; i < 3; i++) send_bit(1'b1, line);
      tick(6);
      check("rstrd_oe_before_rst", 8'(sda_oe), 8'd1);
      #2 rst = 1'b0;
      #1;
      check("rstrd_oe_async", 8'(sda_oe),  8'd0);
      check("rstrd_busy",     8'(busy),    8'd0);
      check("rstrd_wr_data",  wr_data,     8'h00);
      for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
      $display("txn reset during read");
      tick(4);
      rst = 1'b1;
      tick(2);
      sda_m = 1'b1;
      tick(4);
      scl = 1'b1;
      tick(8);
      check("rstrd_busy_after", 8'(busy), 8'd0);

      write_row('{8'h80, 8'h05, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b1}, 7);
      read_regs(8'h05, 1);
      read_regs(8'h01, 1);

      tick(10);
      check("sb_empty", 8'(sb_q.size()), 8'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_slave_regs.md
I2C_SLAVE_REGS -- requirements
Module: i2c_slave_regs

Interface
REQ-001 Parameter DEV_ADDR, 7'b1000000, 7-bit I2C address this slave answers to.
REQ-002 Parameter NREG, 16, number of 8-bit registers; inner addresses 0..NREG-1 are valid.
REQ-003 clk  input  1  system clock; oversamples SCL/SDA at ≥8x the SCL rate.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 scl  input  1  I2C clock from the master.
REQ-006 sda_in  input  1  sampled SDA line level.
REQ-007 sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-008 busy  output  1  high from a START addressed to this device until the STOP or the next START.
REQ-009 wr_valid  output  1  one-clk pulse per register write.
REQ-010 wr_addr  output  8  inner address written; valid with wr_valid.
REQ-011 wr_data  output  8  byte written; valid with wr_valid.

Function
REQ-012 scl and sda_in SHALL pass through 2-flop synchronizers; edge and condition detection SHALL use the synchronized values only.
REQ-013 START (SDA falls while SCL high) in any state SHALL go to ADDR and clear the bit counter; this also covers a repeated START.
REQ-014 STOP (SDA rises while SCL high) in any state SHALL go to IDLE with sda_oe=0 and busy=0.
REQ-015 States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
REQ-016 Received bits SHALL be sampled on SCL rising edges, MSB first. sda_oe SHALL change only on SCL falling edges, except on STOP and reset.
REQ-017 ADDR: after 8 bits, if bits[7:1]==DEV_ADDR the block SHALL go to ADDR_ACK, set busy, and drive ACK (sda_oe=1) from the next SCL fall to the following SCL fall. On mismatch it SHALL go to WAIT_STOP without ACK.
REQ-018 After ADDR_ACK: if R/W=0, go to REG. If R/W=1, go to RDATA and drive MSB of reg[ptr] on that same SCL fall.
REQ-019 REG: if the received byte is < NREG, load it into ptr and ACK, then go to WDATA. Otherwise NACK (sda_oe=0) and go to WAIT_STOP.
REQ-020 WDATA: after 8 bits, write reg[ptr], pulse wr_valid for exactly one clk with wr_addr=ptr and wr_data=byte, ACK, and increment ptr.
REQ-021 ptr SHALL wrap from NREG-1 to 0; further bytes continue writing (burst write).
REQ-022 RDATA: sda_oe=~bit on each SCL fall for 8 bits, then release SDA for the master's ACK bit and increment ptr (wrapping).
REQ-023 RDATA_ACK: master ACK (SDA=0 at SCL rise) SHALL go to RDATA and load the next byte. Master NACK SHALL go to WAIT_STOP with SDA released.
REQ-024 ptr SHALL persist across transactions, so write-address-then-Sr-read performs a random read.
REQ-025 WAIT_STOP SHALL ignore bits and hold sda_oe=0 until START or STOP.
REQ-026 sda_oe SHALL never be asserted while busy=0.

Reset
REQ-027 While rst=0: sda_oe=0, busy=0, wr_valid=0, wr_addr=0, wr_data=0, ptr=0, every reg=8'h00, state=IDLE, synchronizers=1.
REQ-028 Reset asserted mid-transfer SHALL release SDA immediately (asynchronously). After release the block SHALL ignore the bus until the next START.

Verification
REQ-029 START, 0x80, 0x01, 0xBA, STOP -> ACK on all 3 slots; wr_valid once with wr_addr=0x01, wr_data=0xBA; reg[1]=0xBA.
REQ-030 After REQ-029: START, 0x80, 0x01, Sr, 0x81, read 1 byte with NACK, STOP -> SDA bits 1,0,1,1,1,0,1,0; sda_oe=0 after NACK.
REQ-031 START, 0x82 (addr 0x41) -> no ACK; bus ignored, wr_valid stays 0, busy stays 0 through STOP.
REQ-032 START, 0x80, 0x10 -> NACK on the register byte; no writes until STOP.
REQ-033 START, 0x80, 0x0F, 0x11, 0x22, STOP -> reg[15]=0x11, reg[0]=0x22, two wr_valid pulses.
REQ-034 Assert rst during bit 4 of a read data byte -> sda_oe=0 immediately; next valid transaction completes normally.
